// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one backing-memory port between the icache refill path
// and the MSHR. Only one transaction is outstanding at a time; a watchdog aborts a stuck memory.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_req,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_ack,
  output logic [DATA_W-1:0] ic_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              err
);

  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;
  localparam logic [WD_W-1:0] WD_MAX  = '1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_nx;
  logic              last_dm, last_dm_nx;
  logic              win_dm, win_dm_nx;
  logic              lat_we, lat_we_nx;
  logic [ADDR_W-1:0] lat_addr, lat_addr_nx;
  logic [DATA_W-1:0] lat_wdata, lat_wdata_nx;
  logic [WD_W-1:0]   wdog, wdog_nx;
  logic              err_nx;
  logic [DATA_W-1:0] ic_rdata_nx, dm_rdata_nx;
  logic              grant_dm;
  logic [DATA_W-1:0] resp_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_dm   <= 1'b1;
      win_dm    <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wdog      <= '0;
      err       <= 1'b0;
      ic_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      state     <= state_nx;
      last_dm   <= last_dm_nx;
      win_dm    <= win_dm_nx;
      lat_we    <= lat_we_nx;
      lat_addr  <= lat_addr_nx;
      lat_wdata <= lat_wdata_nx;
      wdog      <= wdog_nx;
      err       <= err_nx;
      ic_rdata  <= ic_rdata_nx;
      dm_rdata  <= dm_rdata_nx;
    end
  end

  // On a tie the requester that was not served last wins; last_dm only moves on a real mem_ack.
  always_comb begin
    state_nx     = state;
    last_dm_nx   = last_dm;
    win_dm_nx    = win_dm;
    lat_we_nx    = lat_we;
    lat_addr_nx  = lat_addr;
    lat_wdata_nx = lat_wdata;
    wdog_nx      = wdog;
    err_nx       = err;
    ic_rdata_nx  = ic_rdata;
    dm_rdata_nx  = dm_rdata;
    grant_dm     = dm_req & (~ic_req | ~last_dm);
    resp_data    = lat_we ? '0 : mem_rdata;

    case (state)
      IDLE: begin
        if (ic_req | dm_req) begin
          win_dm_nx    = grant_dm;
          lat_we_nx    = grant_dm & dm_we;
          lat_addr_nx  = grant_dm ? dm_addr : ic_addr;
          lat_wdata_nx = grant_dm ? dm_wdata : '0;
          wdog_nx      = '0;
          state_nx     = BUSY;
        end
      end
      BUSY: begin
        if (mem_ack) begin
          if (win_dm) dm_rdata_nx = resp_data;
          else        ic_rdata_nx = resp_data;
          last_dm_nx = win_dm;
          state_nx   = RESP;
        end else begin
          if (wdog != WD_MAX) wdog_nx = wdog + 1'b1;
          if ((TIMEOUT != 0) && (wdog == WD_LAST)) begin
            err_nx = 1'b1;
            if (win_dm) dm_rdata_nx = '0;
            else        ic_rdata_nx = '0;
            state_nx = RESP;
          end
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign mem_req   = (state == BUSY);
  assign mem_we    = (state == BUSY) & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign ic_ack    = (state == RESP) & ~win_dm;
  assign dm_ack    = (state == RESP) & win_dm;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a behavioural memory responder plus a round-robin
// reference model that predicts the winner, memory fields, read data and latency.
module tb_mem_arbiter;
  localparam int TIMEOUT = 8;

  logic        clk, rst;
  logic        ic_req, ic_ack;
  logic [31:0] ic_addr, ic_rdata;
  logic        dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, err;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit ref_last_dm;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          stable;
    int          ncyc;
    bit          acked;
    logic [31:0] rdata;
  } mem_rec_t;

  mem_rec_t    mon_q[$];
  mem_rec_t    cur;
  int          mon_cnt = 0;
  int          mem_delay = 0;
  bit          mem_never = 0;
  bit          fixed_en = 0;
  logic [31:0] fixed_val = 32'h0;
  bit          inject_ack = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr), .ic_ack(ic_ack), .ic_rdata(ic_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory responder: acks mem_delay cycles into a request and logs each request's fields.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (mem_req === 1'b1) begin
      if (mon_cnt == 0) begin
        cur.we = mem_we; cur.addr = mem_addr; cur.wdata = mem_wdata;
        cur.stable = 1'b1; cur.acked = 1'b0; cur.rdata = 32'h0;
      end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
        cur.stable = 1'b0;
      end
      if (!mem_never && !cur.acked && mon_cnt == mem_delay) begin
        mem_ack   = 1'b1;
        mem_rdata = fixed_en ? fixed_val : $urandom;
        cur.rdata = mem_rdata;
        cur.acked = 1'b1;
      end
      mon_cnt++;
    end else begin
      if (mon_cnt > 0) begin
        cur.ncyc = mon_cnt;
        mon_q.push_back(cur);
        mon_cnt = 0;
      end
      if (inject_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = $urandom;
      end
    end
  end

  function automatic bit pick_dm(bit ic, bit dm, bit last_dm);
    if (ic && !dm) return 1'b0;
    if (dm && !ic) return 1'b1;
    return !last_dm;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    ref_last_dm = 1'b1;
    #1;
  endtask

  task automatic wait_ack(input int max_cyc, output int n, output bit gi, output bit gd,
                          output logic [31:0] rd);
    n = 0; gi = 1'b0; gd = 1'b0; rd = 32'h0;
    while (n < max_cyc) begin
      @(negedge clk);
      n++;
      if (ic_ack === 1'b1 || dm_ack === 1'b1) begin
        gi = ic_ack; gd = dm_ack;
        rd = (ic_ack === 1'b1) ? ic_rdata : dm_rdata;
        if (ic_ack === 1'b1) ic_req = 1'b0;
        if (dm_ack === 1'b1) dm_req = 1'b0;
        #1;
        return;
      end
    end
    n = -1;
    #1;
  endtask

  task automatic get_rec(output mem_rec_t r, output bit ok);
    ok = (mon_q.size() > 0);
    if (ok) r = mon_q.pop_front();
    else    r = '{default: '0};
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if ({busy, mem_req} !== 2'b00) $display("[TB] FAIL rst_busy: got %b, want 00", {busy, mem_req}); else n_pass++;
    n_checks++; if ({ic_ack, dm_ack} !== 2'b00) $display("[TB] FAIL rst_acks: got %b, want 00", {ic_ack, dm_ack}); else n_pass++;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL rst_err: got %b, want 0", err); else n_pass++;
    n_checks++; if ({mem_we, mem_addr, mem_wdata} !== 65'h0) $display("[TB] FAIL rst_mem: got %h, want 0", {mem_we, mem_addr, mem_wdata}); else n_pass++;
    n_checks++; if ({ic_rdata, dm_rdata} !== 64'h0) $display("[TB] FAIL rst_rdata: got %h, want 0", {ic_rdata, dm_rdata}); else n_pass++;
    inject_ack = 1'b1;
    @(negedge clk); #1;
    inject_ack = 1'b0;
    @(negedge clk); #1;
    n_checks++; if ({busy, mem_req, ic_ack, dm_ack} !== 4'b0) $display("[TB] FAIL stray_ack: got %b, want 0000", {busy, mem_req, ic_ack, dm_ack}); else n_pass++;
  endtask

  task automatic test_ic_only();
    int n; bit gi, gd, ok; logic [31:0] rd; mem_rec_t r;
    mon_q.delete(); mem_never = 0; fixed_en = 1; fixed_val = 32'hDEADBEEF; mem_delay = 2;
    @(negedge clk);
    ic_addr = 32'h100; ic_req = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({busy, mem_req} !== 2'b11) $display("[TB] FAIL ic_busy: got %b, want 11", {busy, mem_req}); else n_pass++;
    wait_ack(20, n, gi, gd, rd);
    n_checks++; if (n != 3) $display("[TB] FAIL ic_latency: got %0d, want 3", n); else n_pass++;
    n_checks++; if ({gi, gd} !== 2'b10) $display("[TB] FAIL ic_who: got %b, want 10", {gi, gd}); else n_pass++;
    n_checks++; if (rd !== 32'hDEADBEEF) $display("[TB] FAIL ic_rdata: got %h, want deadbeef", rd); else n_pass++;
    get_rec(r, ok);
    n_checks++; if ({ok, r.stable, r.we, r.addr, r.wdata} !== {3'b110, 32'h100, 32'h0}) $display("[TB] FAIL ic_memfields: got %h, want %h", {ok, r.stable, r.we, r.addr, r.wdata}, {3'b110, 32'h100, 32'h0}); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if ({ic_ack, dm_ack} !== 2'b00) $display("[TB] FAIL ic_pulse: got %b, want 00", {ic_ack, dm_ack}); else n_pass++;
    ref_last_dm = 1'b0; fixed_en = 0;
  endtask

  task automatic test_tie();
    int n, n_ic, n_dm; bit gi, gd, ok, exp_dm; logic [31:0] rd; mem_rec_t r;
    apply_reset();
    mon_q.delete(); n_ic = 0; n_dm = 0;
    ic_addr = $urandom; dm_we = 1'b0; dm_addr = $urandom; dm_wdata = $urandom;
    ic_req = 1'b1; dm_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_delay = $urandom_range(0, 3);
      exp_dm = pick_dm(1'b1, 1'b1, ref_last_dm);
      wait_ack(20, n, gi, gd, rd);
      n_checks++; if ({gi, gd} !== {!exp_dm, exp_dm}) $display("[TB] FAIL tie_grant_%0d: got %b, want %b", i, {gi, gd}, {!exp_dm, exp_dm}); else n_pass++;
      get_rec(r, ok);
      n_checks++; if ({ok, rd} !== {1'b1, r.rdata}) $display("[TB] FAIL tie_rdata_%0d: got %h, want %h", i, {ok, rd}, {1'b1, r.rdata}); else n_pass++;
      if (gi) n_ic++;
      if (gd) n_dm++;
      ref_last_dm = exp_dm;
      if (i < 5) begin
        @(negedge clk);
        if (exp_dm) begin dm_addr = $urandom; dm_req = 1'b1; end
        else begin ic_addr = $urandom; ic_req = 1'b1; end
      end
    end
    ic_req = 1'b0; dm_req = 1'b0;
    n_checks++; if ({n_ic, n_dm} !== {32'd3, 32'd3}) $display("[TB] FAIL tie_fairness: got ic=%0d dm=%0d, want 3/3", n_ic, n_dm); else n_pass++;
  endtask

  task automatic test_eviction();
    int n; bit gi, gd, ok; logic [31:0] rd; mem_rec_t r;
    mon_q.delete(); mem_delay = 3;
    @(negedge clk);
    dm_we = 1'b1; dm_addr = 32'h2000; dm_wdata = 32'h12345678; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    dm_we = 1'b0; dm_addr = $urandom; dm_wdata = $urandom;
    #1;
    n_checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 32'h2000, 32'h12345678}) $display("[TB] FAIL evict_latched: got %h, want %h", {mem_we, mem_addr, mem_wdata}, {1'b1, 32'h2000, 32'h12345678}); else n_pass++;
    wait_ack(20, n, gi, gd, rd);
    n_checks++; if ({gi, gd} !== 2'b01) $display("[TB] FAIL evict_who: got %b, want 01", {gi, gd}); else n_pass++;
    n_checks++; if (rd !== 32'h0) $display("[TB] FAIL evict_rdata: got %h, want 0", rd); else n_pass++;
    n_checks++; if (n != 3) $display("[TB] FAIL evict_latency: got %0d, want 3", n); else n_pass++;
    get_rec(r, ok);
    n_checks++; if ({ok, r.stable, r.we, r.addr, r.wdata} !== {3'b111, 32'h2000, 32'h12345678}) $display("[TB] FAIL evict_memfields: got %h, want %h", {ok, r.stable, r.we, r.addr, r.wdata}, {3'b111, 32'h2000, 32'h12345678}); else n_pass++;
    ref_last_dm = 1'b1; dm_we = 1'b0;
  endtask

  task automatic test_back_to_back();
    int n, t_prev; bit gi, gd, ok; logic [31:0] rd; mem_rec_t r;
    mon_q.delete(); mem_delay = 0;
    @(negedge clk);
    ic_addr = $urandom; ic_req = 1'b1; t_prev = cyc;
    for (int k = 0; k < 4; k++) begin
      wait_ack(10, n, gi, gd, rd);
      n_checks++; if (cyc - t_prev != ((k == 0) ? 2 : 3)) $display("[TB] FAIL b2b_gap_%0d: got %0d, want %0d", k, cyc - t_prev, (k == 0) ? 2 : 3); else n_pass++;
      get_rec(r, ok);
      n_checks++; if ({ok, gi, r.ncyc} !== {2'b11, 32'd1}) $display("[TB] FAIL b2b_memreq_%0d: got %h, want %h", k, {ok, gi, r.ncyc}, {2'b11, 32'd1}); else n_pass++;
      t_prev = cyc;
      if (k < 3) begin
        @(negedge clk);
        ic_addr = $urandom; ic_req = 1'b1;
      end
    end
    ref_last_dm = 1'b0;
  endtask

  task automatic test_random();
    int n; bit gi, gd, ok, exp_dm, ic_pend, dm_pend; logic [31:0] rd; mem_rec_t r;
    logic [64:0] exp_f;
    mon_q.delete(); ic_pend = 0; dm_pend = 0;
    for (int it = 0; it < 30; it++) begin
      @(negedge clk);
      if (!ic_pend && $urandom_range(0, 1) == 1) begin ic_addr = $urandom; ic_req = 1'b1; ic_pend = 1; end
      if (!dm_pend && $urandom_range(0, 1) == 1) begin
        dm_we = $urandom_range(0, 1); dm_addr = $urandom; dm_wdata = $urandom; dm_req = 1'b1; dm_pend = 1;
      end
      if (!ic_pend && !dm_pend) begin ic_addr = $urandom; ic_req = 1'b1; ic_pend = 1; end
      mem_delay = $urandom_range(0, 5);
      exp_dm = pick_dm(ic_pend, dm_pend, ref_last_dm);
      exp_f = exp_dm ? {dm_we, dm_addr, dm_wdata} : {1'b0, ic_addr, 32'h0};
      wait_ack(20, n, gi, gd, rd);
      get_rec(r, ok);
      n_checks++; if ({gi, gd} !== {!exp_dm, exp_dm}) $display("[TB] FAIL rnd_who_%0d: got %b, want %b", it, {gi, gd}, {!exp_dm, exp_dm}); else n_pass++;
      n_checks++; if ({ok, r.stable, r.we, r.addr, r.wdata} !== {2'b11, exp_f}) $display("[TB] FAIL rnd_mem_%0d: got %h, want %h", it, {ok, r.stable, r.we, r.addr, r.wdata}, {2'b11, exp_f}); else n_pass++;
      n_checks++; if (rd !== (exp_f[64] ? 32'h0 : r.rdata)) $display("[TB] FAIL rnd_rdata_%0d: got %h, want %h", it, rd, exp_f[64] ? 32'h0 : r.rdata); else n_pass++;
      n_checks++; if (n != 2 + mem_delay) $display("[TB] FAIL rnd_latency_%0d: got %0d, want %0d", it, n, 2 + mem_delay); else n_pass++;
      ref_last_dm = exp_dm;
      if (exp_dm) dm_pend = 0; else ic_pend = 0;
    end
    ic_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
  endtask

  task automatic test_watchdog();
    int n; bit gi, gd, ok; logic [31:0] rd; mem_rec_t r;
    mon_q.delete(); mem_never = 0; mem_delay = TIMEOUT - 1;
    @(negedge clk); #1;
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL wd_err_clear: got %b, want 0", err); else n_pass++;
    ic_addr = $urandom; ic_req = 1'b1;
    wait_ack(30, n, gi, gd, rd);
    get_rec(r, ok);
    n_checks++; if ({n, gi, err, ok} !== {TIMEOUT + 1, 3'b101}) $display("[TB] FAIL wd_last_cycle_ack: got n=%0d ic=%b err=%b, want n=%0d ic=1 err=0", n, gi, err, TIMEOUT + 1); else n_pass++;
    n_checks++; if (rd !== r.rdata) $display("[TB] FAIL wd_last_cycle_rdata: got %h, want %h", rd, r.rdata); else n_pass++;
    ref_last_dm = 1'b0;
    @(negedge clk);
    mem_never = 1; ic_addr = $urandom; ic_req = 1'b1;
    wait_ack(30, n, gi, gd, rd);
    get_rec(r, ok);
    n_checks++; if (n != TIMEOUT + 1) $display("[TB] FAIL wd_abort_latency: got %0d, want %0d", n, TIMEOUT + 1); else n_pass++;
    n_checks++; if ({gi, gd, rd, err} !== {2'b10, 32'h0, 1'b1}) $display("[TB] FAIL wd_abort_resp: got %h, want %h", {gi, gd, rd, err}, {2'b10, 32'h0, 1'b1}); else n_pass++;
    n_checks++; if ({ok, r.acked, r.ncyc} !== {2'b10, TIMEOUT}) $display("[TB] FAIL wd_busy_cycles: got %h, want %h", {ok, r.acked, r.ncyc}, {2'b10, TIMEOUT}); else n_pass++;
    @(negedge clk); #1;
    n_checks++; if ({busy, err} !== 2'b01) $display("[TB] FAIL wd_idle: got %b, want 01", {busy, err}); else n_pass++;
    mem_never = 0; mem_delay = 1; ic_req = 1'b1;
    wait_ack(20, n, gi, gd, rd);
    n_checks++; if ({gi, err} !== 2'b11) $display("[TB] FAIL wd_sticky: got %b, want 11", {gi, err}); else n_pass++;
    apply_reset();
    n_checks++; if (err !== 1'b0) $display("[TB] FAIL wd_rst_clear: got %b, want 0", err); else n_pass++;
  endtask

  task automatic test_reset_mid_busy();
    int n; bit gi, gd, saw, exp_dm; logic [31:0] rd;
    mem_never = 0; mem_delay = 1;
    @(negedge clk);
    ic_addr = $urandom; ic_req = 1'b1;
    wait_ack(20, n, gi, gd, rd);
    n_checks++; if (gi !== 1'b1) $display("[TB] FAIL rmb_pre: got %b, want 1", gi); else n_pass++;
    ref_last_dm = 1'b0;
    @(negedge clk);
    mem_never = 1; dm_we = 1'b0; dm_addr = $urandom; dm_req = 1'b1;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++; if ({busy, mem_req} !== 2'b11) $display("[TB] FAIL rmb_busy: got %b, want 11", {busy, mem_req}); else n_pass++;
    rst = 1'b1;
    @(negedge clk); #1;
    n_checks++; if ({mem_req, busy, ic_ack, dm_ack} !== 4'b0) $display("[TB] FAIL rmb_after_rst: got %b, want 0000", {mem_req, busy, ic_ack, dm_ack}); else n_pass++;
    rst = 1'b0; dm_req = 1'b0; ref_last_dm = 1'b1; saw = 0;
    repeat (4) begin
      @(negedge clk); #1;
      if (ic_ack !== 1'b0 || dm_ack !== 1'b0 || mem_req !== 1'b0) saw = 1;
    end
    n_checks++; if (saw !== 1'b0) $display("[TB] FAIL rmb_no_ack: got %b, want 0", saw); else n_pass++;
    mon_q.delete(); mem_never = 0; mem_delay = $urandom_range(0, 3);
    ic_addr = $urandom; dm_addr = $urandom; ic_req = 1'b1; dm_req = 1'b1;
    exp_dm = pick_dm(1'b1, 1'b1, ref_last_dm);
    wait_ack(20, n, gi, gd, rd);
    n_checks++; if ({gi, gd} !== {!exp_dm, exp_dm}) $display("[TB] FAIL rmb_tie: got %b, want %b", {gi, gd}, {!exp_dm, exp_dm}); else n_pass++;
    wait_ack(20, n, gi, gd, rd);
    n_checks++; if ({gi, gd} !== {exp_dm, !exp_dm}) $display("[TB] FAIL rmb_second: got %b, want %b", {gi, gd}, {exp_dm, !exp_dm}); else n_pass++;
    ic_req = 1'b0; dm_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation still running, want finished");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    rst = 1'b1; ic_req = 1'b0; ic_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    ref_last_dm = 1'b1;
    test_reset();
    test_ic_only();
    test_tie();
    test_eviction();
    test_back_to_back();
    test_random();
    test_watchdog();
    test_reset_mid_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
